// File: rtl/hero_write_rx.sv
// Receive side of the hero write bus: frames pushed beats into transactions and
// buffers them in a FIFO exposed as a valid/ready stream with a last marker.
module hero_write_rx #(
  parameter int unsigned HERO_WIDTH = 36,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [HERO_WIDTH+4:0]         hero_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [HERO_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   txn_cnt,
  output logic                          err_overflow,
  output logic                          err_protocol,
  input  logic                          err_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(MAX_BEATS) + 1;
  localparam int unsigned EW = HERO_WIDTH + 2;

  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BEATS - 1);
  localparam logic [3:0]    CT_VALID = 4'd1;
  localparam logic [3:0]    CT_DONE  = 4'd2;

  typedef enum logic [1:0] {S_IDLE, S_TXN, S_DROP} state_t;

  state_t               r_state, w_state_nxt;
  logic [HERO_WIDTH+4:0] r_in;
  logic [BW-1:0]        r_beat_cnt, w_beat_nxt;
  logic                 r_term_pend, w_term_nxt;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;
  logic [15:0]          r_txn;
  logic                 r_ovf, r_prot;

  logic [3:0]            w_ct;
  logic [HERO_WIDTH-1:0] w_dat;
  logic                  w_en, w_qual, w_illegal, w_is_done;
  logic                  w_pop, w_can_push, w_room, w_push;
  logic [EW-1:0]         w_push_ent, w_head;
  logic                  w_set_ovf, w_set_prot;

  assign w_ct      = r_in[HERO_WIDTH+4:HERO_WIDTH+1];
  assign w_dat     = r_in[HERO_WIDTH:1];
  assign w_en      = r_in[0];
  assign w_is_done = (w_ct == CT_DONE);
  assign w_qual    = w_en && ((w_ct == CT_VALID) || w_is_done);
  assign w_illegal = w_en && (w_ct > CT_DONE);

  assign w_head     = r_mem[r_rptr];
  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? w_head[HERO_WIDTH-1:0] : '0;
  assign out_last   = out_valid & w_head[HERO_WIDTH];
  assign out_err    = out_valid & w_head[HERO_WIDTH+1];
  assign fifo_count = r_count;
  assign txn_cnt    = r_txn;
  assign err_overflow = r_ovf;
  assign err_protocol = r_prot;

  assign w_pop      = out_valid && out_ready;
  assign w_can_push = (r_count < DEPTH_C) || w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_term_nxt  = r_term_pend;
    w_push      = 1'b0;
    w_push_ent  = '0;
    w_set_ovf   = 1'b0;
    w_set_prot  = 1'b0;
    w_room      = w_can_push;
    // A pending terminator claims the free slot ahead of any incoming beat.
    if (r_term_pend && w_can_push) begin
      w_push     = 1'b1;
      w_push_ent = {1'b1, 1'b1, {HERO_WIDTH{1'b0}}};
      w_term_nxt = 1'b0;
      w_room     = 1'b0;
    end
    if (w_illegal) begin
      w_set_prot = 1'b1;
    end else if (w_qual) begin
      case (r_state)
        S_IDLE, S_TXN: begin
          if (!w_room) begin
            w_set_ovf   = 1'b1;
            w_beat_nxt  = '0;
            w_state_nxt = w_is_done ? S_IDLE : S_DROP;
            if (r_state == S_TXN) w_term_nxt = 1'b1;
          end else if (w_is_done) begin
            w_push      = 1'b1;
            w_push_ent  = {1'b0, 1'b1, w_dat};
            w_beat_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else if ((r_state == S_TXN) && (r_beat_cnt == LAST_CNT)) begin
            w_push      = 1'b1;
            w_push_ent  = {1'b0, 1'b1, w_dat};
            w_set_prot  = 1'b1;
            w_beat_nxt  = '0;
            w_state_nxt = S_DROP;
          end else begin
            w_push      = 1'b1;
            w_push_ent  = {1'b0, 1'b0, w_dat};
            w_beat_nxt  = r_beat_cnt + 1'b1;
            w_state_nxt = S_TXN;
          end
        end
        S_DROP: begin
          if (w_is_done) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in        <= '0;
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_term_pend <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_txn       <= '0;
      r_ovf       <= 1'b0;
      r_prot      <= 1'b0;
    end else begin
      r_in        <= hero_in;
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_term_pend <= w_term_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_push_ent[HERO_WIDTH]) r_txn <= r_txn + 1'b1;
      // A new error event takes precedence over a clear in the same cycle.
      if (w_set_ovf)    r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_set_prot)   r_prot <= 1'b1;
      else if (err_clr) r_prot <= 1'b0;
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_ent;
  end

endmodule
